split_sample_driver: RTL and testbench

- Driver end of the split constraint-block interface. A split block consumes a packed vector of variable assignments and returns one satisfaction bit, x.
- This block generates pseudo-random candidate vectors and presents them to a split block.
- It samples the returned bit and streams satisfying vectors out on a valid/ready interface until a target count or a try limit is reached.
- It sits between solver control and any split_N instance under test or in use.

---
 rtl/split_drv_pkg.sv | 20 ++
 rtl/split_lfsr32_adv.sv | 17 +
 rtl/split_sample_driver.sv | 172 +++++++++++++++++
 tb/tb_split_sample_driver.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/split_drv_pkg.sv
// Shared types and constants for the split-block sample driver.
// The LFSR is a right-shifting Galois register; the taps implement x^32+x^22+x^2+x+1.
package split_drv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      CHECK,
      EMIT,
      DONE
   } state_t;

   localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
   localparam logic [31:0] SEED_ZERO_SUB = 32'h0000_0001;

   function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
      return {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/split_lfsr32_adv.sv
// Combinational 32-step advance of the candidate LFSR.
// One call produces a fresh 32-bit candidate word.
module split_lfsr32_adv
   import split_drv_pkg::*;
(
   input  logic [31:0] state,
   output logic [31:0] state_next
);

   always_comb begin
      state_next = state;
      for (int i = 0; i < 32; i++) begin
         state_next = lfsr_step(state_next);
      end
   end

endmodule

// File: rtl/split_sample_driver.sv
// Driver end of the split constraint-block interface: generates LFSR candidates,
// samples the returned satisfaction bit and streams satisfying vectors out.
//
// state | meaning
// IDLE  | waiting for start; counters and fail hold the last run's result
// FILL  | one LFSR word per cycle written into cand_vec, low word first
// CHECK | cand_valid high; sat_in sampled when wait_cnt reaches CHK_LAT
// EMIT  | sol_vec offered downstream until sol_ready
// DONE  | done pulse cycle; start is not accepted here
module split_sample_driver
   import split_drv_pkg::*;
#(
   parameter int VEC_W   = 64,
   parameter int CHK_LAT = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      seed,
   input  logic [15:0]      target_cnt,
   input  logic [31:0]      max_tries,
   output logic [VEC_W-1:0] cand_vec,
   output logic             cand_valid,
   input  logic             sat_in,
   output logic [VEC_W-1:0] sol_vec,
   output logic             sol_valid,
   input  logic             sol_ready,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [31:0]      tries_cnt,
   output logic [15:0]      sol_cnt
);

   localparam int              NW        = (VEC_W + 31) / 32;
   localparam int              WI_W      = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [WI_W-1:0] LAST_WORD = WI_W'(NW - 1);
   localparam logic [2:0]      CHK_LAT_V = 3'(CHK_LAT);

   state_t          state;
   logic [31:0]     lfsr;
   logic [31:0]     lfsr_adv;
   logic [WI_W-1:0] word_idx;
   logic [2:0]      wait_cnt;
   logic [15:0]     target_q;
   logic [31:0]     max_q;
   logic [31:0]     tries_inc;
   logic [15:0]     sol_inc;
   logic            limit_after_check;
   logic            limit_now;

   split_lfsr32_adv u_adv (
      .state      (lfsr),
      .state_next (lfsr_adv)
   );

   // Saturation only matters for unlimited runs; a limited run stops first.
   assign tries_inc         = (tries_cnt == 32'hFFFF_FFFF) ? tries_cnt : tries_cnt + 32'd1;
   assign sol_inc           = sol_cnt + 16'd1;
   assign limit_after_check = (max_q != 32'd0) && (tries_inc == max_q);
   assign limit_now         = (max_q != 32'd0) && (tries_cnt == max_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         lfsr       <= SEED_ZERO_SUB;
         word_idx   <= '0;
         wait_cnt   <= '0;
         target_q   <= '0;
         max_q      <= '0;
         cand_vec   <= '0;
         cand_valid <= 1'b0;
         sol_vec    <= '0;
         sol_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fail       <= 1'b0;
         tries_cnt  <= '0;
         sol_cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lfsr      <= (seed == 32'd0) ? SEED_ZERO_SUB : seed;
                  target_q  <= target_cnt;
                  max_q     <= max_tries;
                  tries_cnt <= '0;
                  sol_cnt   <= '0;
                  fail      <= 1'b0;
                  word_idx  <= '0;
                  if (target_cnt == 16'd0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     busy     <= 1'b1;
                     cand_vec <= '0;
                     state    <= FILL;
                  end
               end
            end

            FILL: begin
               lfsr <= lfsr_adv;
               // The final word is truncated simply by having no bits above VEC_W-1.
               for (int b = 0; b < VEC_W; b++) begin
                  if (word_idx == WI_W'(b / 32)) begin
                     cand_vec[b] <= lfsr_adv[b % 32];
                  end
               end
               if (word_idx == LAST_WORD) begin
                  word_idx   <= '0;
                  cand_valid <= 1'b1;
                  wait_cnt   <= '0;
                  state      <= CHECK;
               end else begin
                  word_idx <= word_idx + WI_W'(1);
               end
            end

            CHECK: begin
               wait_cnt <= wait_cnt + 3'd1;
               if (wait_cnt == CHK_LAT_V) begin
                  tries_cnt  <= tries_inc;
                  cand_valid <= 1'b0;
                  if (sat_in) begin
                     sol_vec   <= cand_vec;
                     sol_valid <= 1'b1;
                     state     <= EMIT;
                  end else if (limit_after_check) begin
                     fail  <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= FILL;
                  end
               end
            end

            EMIT: begin
               if (sol_ready) begin
                  sol_valid <= 1'b0;
                  sol_cnt   <= sol_inc;
                  if (sol_inc == target_q) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else if (limit_now) begin
                     fail  <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= FILL;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_split_sample_driver.sv
// Bench for split_sample_driver: a 64-bit CHK_LAT=0 instance and a 40-bit CHK_LAT=3
// instance, checked against a queue-based model of the candidate/solution stream.
module tb_split_sample_driver;

   localparam int VW0 = 64;
   localparam int VW3 = 40;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start0, start3, sol_ready;
   logic [31:0] seed, max_tries;
   logic [15:0] target_cnt;

   logic [63:0] cand_vec0, sol_vec0;
   logic        cand_valid0, sol_valid0, busy0, done0, fail0, sat0;
   logic [31:0] tries0;
   logic [15:0] solc0;

   logic [39:0] cand_vec3, sol_vec3;
   logic        cand_valid3, sol_valid3, busy3, done3, fail3, sat3;
   logic [31:0] tries3;
   logic [15:0] solc3;

   int          sat_mode;
   logic [63:0] sat_mask;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   split_sample_driver #(.VEC_W(VW0), .CHK_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed), .target_cnt(target_cnt),
      .max_tries(max_tries), .cand_vec(cand_vec0), .cand_valid(cand_valid0), .sat_in(sat0),
      .sol_vec(sol_vec0), .sol_valid(sol_valid0), .sol_ready(sol_ready), .busy(busy0),
      .done(done0), .fail(fail0), .tries_cnt(tries0), .sol_cnt(solc0)
   );

   split_sample_driver #(.VEC_W(VW3), .CHK_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .seed(seed), .target_cnt(target_cnt),
      .max_tries(max_tries), .cand_vec(cand_vec3), .cand_valid(cand_valid3), .sat_in(sat3),
      .sol_vec(sol_vec3), .sol_valid(sol_valid3), .sol_ready(sol_ready), .busy(busy3),
      .done(done3), .fail(fail3), .tries_cnt(tries3), .sol_cnt(solc3)
   );

   // Split-block stand-ins: dut0 programmable, dut3 satisfied by odd vectors.
   always_comb begin
      sat0 = 1'b0;
      if (sat_mode == 1) sat0 = 1'b1;
      else if (sat_mode == 2) sat0 = ^(cand_vec0 & sat_mask);
   end
   assign sat3 = cand_vec3[0];

   bit          sel;
   logic        v_cand_valid, v_sol_valid, v_done, v_busy, v_fail;
   logic [63:0] v_sol_vec;
   logic [31:0] v_tries;
   logic [15:0] v_solc;

   always_comb begin
      if (sel) begin
         v_cand_valid = cand_valid3; v_sol_valid = sol_valid3; v_sol_vec = {24'h0, sol_vec3};
         v_done = done3; v_busy = busy3; v_fail = fail3; v_tries = tries3; v_solc = solc3;
      end else begin
         v_cand_valid = cand_valid0; v_sol_valid = sol_valid0; v_sol_vec = sol_vec0;
         v_done = done0; v_busy = busy0; v_fail = fail0; v_tries = tries0; v_solc = solc0;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   function automatic logic [63:0] gen(inout logic [31:0] st, input int vw);
      logic [63:0] v = '0;
      for (int w = 0; w < (vw + 31) / 32; w++) begin
         for (int i = 0; i < 32; i++) st = step(st);
         for (int i = 0; i < 32; i++) if (w * 32 + i < vw) v[w * 32 + i] = st[i];
      end
      return v;
   endfunction

   function automatic bit model_sat(input bit s, input logic [63:0] c);
      if (s) return c[0];
      if (sat_mode == 1) return 1'b1;
      if (sat_mode == 2) return ^(c & sat_mask);
      return 1'b0;
   endfunction

   logic [63:0] exp_q[$];
   int          exp_tries, exp_sols;
   bit          exp_fail;

   task automatic model_run(input bit s, input logic [31:0] sd, input logic [15:0] t,
                            input logic [31:0] m);
      logic [31:0] st;
      logic [63:0] c;
      exp_q.delete(); exp_tries = 0; exp_sols = 0; exp_fail = 0;
      st = (sd == 32'd0) ? 32'd1 : sd;
      if (t == 16'd0) return;
      for (int guard = 0; guard < 10000; guard++) begin
         c = gen(st, s ? VW3 : VW0);
         exp_tries++;
         if (model_sat(s, c)) begin
            exp_q.push_back(c);
            exp_sols++;
            if (exp_sols == int'(t)) return;
         end
         if (m != 32'd0 && exp_tries == int'(m)) begin
            exp_fail = 1;
            return;
         end
      end
   endtask

   // ---------------- run driver ----------------
   int          first_cv, first_sv, first_done;
   logic [63:0] got_q[$];

   task automatic pulse_start(input bit s);
      @(posedge clk); #1;
      if (s) start3 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0; start3 = 1'b0;
   endtask

   task automatic run(input bit s, input logic [31:0] sd, input logic [15:0] t,
                      input logic [31:0] m, input int rdy_pct, input string tag);
      int cyc, bad_w, len, mism;
      bit seen;
      model_run(s, sd, t, m);
      got_q.delete();
      first_cv = -1; first_sv = -1; first_done = -1;
      bad_w = 0; len = 0; seen = 0; mism = 0;
      sel = s; seed = sd; target_cnt = t; max_tries = m;
      pulse_start(s);
      cyc = 1;
      while (!seen && cyc < 3000) begin
         sol_ready = ($urandom_range(99) < rdy_pct);
         @(negedge clk);
         if (v_cand_valid) begin
            if (first_cv < 0) first_cv = cyc;
            len++;
         end else if (len != 0) begin
            if (len != (s ? 4 : 1)) bad_w++;
            len = 0;
         end
         if (v_sol_valid && first_sv < 0) first_sv = cyc;
         if (v_sol_valid && sol_ready) got_q.push_back(v_sol_vec);
         if (v_done) begin
            seen = 1;
            first_done = cyc;
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk({tag, "/done_seen"}, 64'(seen), 64'd1);
      chk({tag, "/tries_cnt"}, v_tries, 64'(exp_tries));
      chk({tag, "/sol_cnt"}, v_solc, 64'(exp_sols));
      chk({tag, "/fail"}, v_fail, 64'(exp_fail));
      chk({tag, "/busy_at_done"}, v_busy, 64'd0);
      chk({tag, "/n_solutions"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) mism++;
      chk({tag, "/sol_values"}, mism, 64'd0);
      chk({tag, "/cand_valid_width"}, bad_w, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "/done_pulse_len"}, v_done, 64'd0);
   endtask

   function automatic logic any_out0();
      return |{cand_vec0, cand_valid0, sol_vec0, sol_valid0, busy0, done0, fail0, tries0, solc0};
   endfunction

   typedef struct {
      logic [31:0] sd;
      logic [15:0] t;
      logic [31:0] m;
      int          mode;
      int          rdy;
      int          e_tries;
      int          e_sols;
      bit          e_fail;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int          k, bad, odd_bad;
      logic [63:0] held;
      bit          ok;

      tbl[0] = '{32'h1,         16'd3, 32'd0, 1, 100, 3, 3, 1'b0};
      tbl[1] = '{32'h5,         16'd2, 32'd5, 0, 100, 5, 0, 1'b1};
      tbl[2] = '{32'h0,         16'd3, 32'd0, 1, 60,  3, 3, 1'b0};
      tbl[3] = '{32'h9,         16'd4, 32'd2, 1, 100, 2, 2, 1'b1};
      tbl[4] = '{32'h7,         16'd1, 32'd1, 1, 100, 1, 1, 1'b0};
      tbl[5] = '{32'hDEADBEEF,  16'd0, 32'd7, 1, 100, 0, 0, 1'b0};

      rst_n = 1'b0; start0 = 0; start3 = 0; sol_ready = 0; sel = 0;
      seed = 0; target_cnt = 0; max_tries = 0; sat_mode = 0; sat_mask = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset/dut0_outputs", any_out0(), 64'd0);
      chk("reset/dut3_busy_valid", {busy3, cand_valid3, sol_valid3, done3, fail3}, 64'd0);
      rst_n = 1'b1;

      // Directed table: tied-1, tied-0 with limit, seed 0, limit after emit, target 0.
      foreach (tbl[i]) begin
         sat_mode = tbl[i].mode;
         run(0, tbl[i].sd, tbl[i].t, tbl[i].m, tbl[i].rdy, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d/tries_const", i), tries0, 64'(tbl[i].e_tries));
         chk($sformatf("tbl%0d/solc_const", i), solc0, 64'(tbl[i].e_sols));
         chk($sformatf("tbl%0d/fail_const", i), fail0, 64'(tbl[i].e_fail));
         if (i == 0) begin
            chk("lat/first_cand_valid", first_cv, 64'd3);
            chk("lat/first_sol_valid", first_sv, 64'd4);
         end
         if (i == 5) begin
            chk("tgt0/done_cycle", first_done, 64'd1);
            chk("tgt0/no_candidate", first_cv, -64'sd1);
         end
      end

      // Backpressure: ten stalled cycles with a pending solution.
      sat_mode = 1; sel = 0; seed = 32'h1234; target_cnt = 2; max_tries = 0; sol_ready = 0;
      model_run(0, 32'h1234, 16'd2, 32'd0);
      pulse_start(0);
      k = 0;
      @(negedge clk);
      while (!sol_valid0 && k < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         k++;
      end
      chk("bp/sol_valid_seen", sol_valid0, 64'd1);
      held = sol_vec0; bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (!sol_valid0 || sol_vec0 !== held || cand_valid0 || solc0 != 16'd0 || tries0 != 32'd1)
            bad++;
         @(posedge clk); #1;
         @(negedge clk);
      end
      chk("bp/stall_hold", bad, 64'd0);
      chk("bp/sol_vec", held, exp_q[0]);
      @(posedge clk); #1; sol_ready = 1;
      @(negedge clk);
      chk("bp/solc_before_hs", solc0, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp/solc_after_hs", solc0, 64'd1);
      chk("bp/valid_dropped", sol_valid0, 64'd0);
      k = 0;
      while (!done0 && k < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         k++;
      end
      chk("bp/done", done0, 64'd1);
      chk("bp/final_solc", solc0, 64'd2);

      // start coinciding with done is ignored.
      @(posedge clk); #1; seed = 32'h77; target_cnt = 1; max_tries = 0; sat_mode = 1;
      pulse_start(0);
      k = 0;
      @(negedge clk);
      while (!done0 && k < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         k++;
      end
      start0 = 1'b1;
      @(posedge clk); #1; start0 = 1'b0;
      @(negedge clk);
      chk("start_on_done/busy", busy0, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("start_on_done/no_fill", cand_valid0 | busy0, 64'd0);

      // Randomized runs against the model.
      for (int r = 0; r < 16; r++) begin
         sat_mode = 2;
         sat_mask = {$urandom, $urandom} | 64'h1;
         run(0, $urandom, 16'($urandom_range(1, 4)),
             ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(1, 10)),
             50, $sformatf("rnd%0d", r));
      end

      // Latency-3 instance, satisfied only by odd vectors.
      run(1, 32'hC0FFEE01, 16'd3, 32'd0, 100, "lat3_a");
      odd_bad = 0;
      foreach (got_q[i]) if (!got_q[i][0]) odd_bad++;
      chk("lat3/only_odd", odd_bad, 64'd0);
      for (int r = 0; r < 3; r++)
         run(1, $urandom, 16'($urandom_range(1, 3)), 32'($urandom_range(0, 6)), 70,
             $sformatf("lat3_r%0d", r));

      // Start while busy, then asynchronous reset in the middle of EMIT.
      sel = 0; sat_mode = 1; seed = 32'hACE1; target_cnt = 2; max_tries = 0; sol_ready = 0;
      model_run(0, 32'hACE1, 16'd2, 32'd0);
      pulse_start(0);
      k = 0;
      @(negedge clk);
      while (!sol_valid0 && k < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         k++;
      end
      seed = 32'h5555; target_cnt = 1;
      pulse_start(0);
      @(negedge clk);
      chk("busy_start/sol_vec", sol_vec0, exp_q[0]);
      ok = busy0 && sol_valid0 && tries0 == 32'd1;
      chk("busy_start/still_emit", 64'(ok), 64'd1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset/outputs", any_out0(), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 32'hACE1, 16'd2, 32'd0, 100, "rerun");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
